vga_timing_gen: RTL and testbench

//   Raster source for the sprite renderers. Generates h_counter/v_counter, which the frog and other renderers

---
 rtl/vga_timing_gen_pkg.sv | 48 ++++
 rtl/vga_axis_counter.sv | 46 ++++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared timing defaults, widths and pixel-path types for the VGA raster source
// Purpose: default 640x480@60 timing, counter/colour widths, the pixel-path stage record and
//          (with VGA_TEST_PATTERN_EN) the colour-bar lookup.
// Ports: none (package).
package vga_timing_gen_pkg;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 3;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // One slot of the sync/blank delay line. The bar index rides along so the
  // test pattern stays aligned with the renderers' colour path.
  typedef struct packed {
    logic       hs_n;
    logic       vs_n;
    logic       active;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } stage_t;

  localparam stage_t STAGE_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, default: '0};

`ifdef VGA_TEST_PATTERN_EN
  function automatic rgb_t bar_rgb(input logic [2:0] k);
    rgb_t c;
    c.r = k[2] ? 3'd7 : 3'd0;
    c.g = k[1] ? 3'd7 : 3'd0;
    c.b = k[0] ? 3'd7 : 3'd0;
    return c;
  endfunction
`endif

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with sync and visible decode
// Purpose: counts 0..TOTAL-1 on inc, flags the terminal count, decodes the sync pulse window
//          and the visible region from the current count.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   inc       advance the counter this clk
//   cnt       current position
//   wrap      cnt is at TOTAL-1 (next inc returns to 0)
//   sync_n    active-low sync for the current position
//   visible   current position lies in the visible region
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync_n,
  output logic             visible
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(VISIBLE + FRONT + SYNC);

  assign wrap    = (cnt == LAST);
  assign sync_n  = !((cnt >= SYNC_START) && (cnt < SYNC_END));
  assign visible = (cnt < VIS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync generation and blanked colour output register
// Purpose: pixel divider, h/v counters for the renderers, frame_start pulse, sync/blank delayed
//          by RENDER_LAT to match the renderers, then one output register onto the VGA pins.
//          Optional macro VGA_TEST_PATTERN_EN adds an 8-bar test pattern selected by test_mode.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   h_counter, v_counter          undelayed raster position
//   pix_tick                      counters advance on this clk
//   frame_start                   1-clk pulse as the counters enter 0,0
//   color_r_in/g_in/b_in          renderer colour, RENDER_LAT clks behind the counters
//   test_mode                     test pattern select (only with VGA_TEST_PATTERN_EN)
//   vga_hs, vga_vs                active-low syncs, RENDER_LAT+1 clks behind the counters
//   vga_r, vga_g, vga_b           registered, blanked colour
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int PIX_DIV    = 1,
  parameter int RENDER_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [CNT_W-1:0]   h_counter,
  output logic [CNT_W-1:0]   v_counter,
  output logic               pix_tick,
  output logic               frame_start,
  input  logic [COLOR_W-1:0] color_r_in,
  input  logic [COLOR_W-1:0] color_g_in,
  input  logic [COLOR_W-1:0] color_b_in,
  input  logic               test_mode,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b
);

  localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);

  logic [1:0] div;
  logic       h_wrap, v_wrap;
  logic       h_sync_n, v_sync_n;
  logic       h_vis, v_vis;
  stage_t     cur, dly;
  rgb_t       src, out_rgb;

  // Pixel divider; with PIX_DIV=1 it never leaves 0 so pix_tick stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else begin
      div <= (div == DIV_LAST) ? 2'd0 : div + 2'd1;
    end
  end

  assign pix_tick = (div == 2'd0);

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .clk(clk), .rst(rst), .inc(pix_tick),
    .cnt(h_counter), .wrap(h_wrap), .sync_n(h_sync_n), .visible(h_vis)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .clk(clk), .rst(rst), .inc(pix_tick & h_wrap),
    .cnt(v_counter), .wrap(v_wrap), .sync_n(v_sync_n), .visible(v_vis)
  );

  // Registered so the pulse lands in the clk where the counters read 0,0.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick & h_wrap & v_wrap;
    end
  end

  always_comb begin
    cur        = STAGE_IDLE;
    cur.hs_n   = h_sync_n;
    cur.vs_n   = v_sync_n;
    cur.active = h_vis & v_vis;
`ifdef VGA_TEST_PATTERN_EN
    cur.bar    = 3'(({3'b000, h_counter} << 3) / 13'(H_VISIBLE));
`endif
  end

  // Delay line matching the renderers' colour latency; advances every clk.
  if (RENDER_LAT == 0) begin : g_no_delay
    assign dly = cur;
  end else begin : g_delay
    stage_t sh [RENDER_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < RENDER_LAT; i++) sh[i] <= STAGE_IDLE;
      end else begin
        sh[0] <= cur;
        for (int i = 1; i < RENDER_LAT; i++) sh[i] <= sh[i-1];
      end
    end

    assign dly = sh[RENDER_LAT-1];
  end

`ifdef VGA_TEST_PATTERN_EN
  assign src = test_mode ? bar_rgb(dly.bar)
                         : '{r: color_r_in, g: color_g_in, b: color_b_in};
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign src = '{r: color_r_in, g: color_g_in, b: color_b_in};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
      out_rgb <= '0;
    end else begin
      vga_hs  <= dly.hs_n;
      vga_vs  <= dly.vs_n;
      out_rgb <= dly.active ? src : '0;
    end
  end

  assign vga_r = out_rgb.r;
  assign vga_g = out_rgb.g;
  assign vga_b = out_rgb.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen against a raster model
module tb_vga_timing_gen;

  localparam int HV = 20, HF = 4, HS = 6, HB = 5, HT = HV + HF + HS + HB;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  localparam int DA = 1, LA = 1;
  localparam int DB = 2, LB = 2;
  localparam int HIST = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cr = '0, cg = '0, cb = '0;
  logic       tm = 1'b0;

  logic [9:0] h_a, v_a, h_b, v_b;
  logic       pt_a, fs_a, hs_a, vs_a, pt_b, fs_b, hs_b, vs_b;
  logic [2:0] r_a, g_a, b_a, r_b, g_b, b_b;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  int cyc = 0;
  int last_fs_a = -1;
  int last_fs_b = -1;
  logic [8:0] col_hist [HIST];
  logic       tm_hist  [HIST];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIX_DIV(DA), .RENDER_LAT(LA)
  ) u_a (
    .clk(clk), .rst(rst), .h_counter(h_a), .v_counter(v_a), .pix_tick(pt_a),
    .frame_start(fs_a), .color_r_in(cr), .color_g_in(cg), .color_b_in(cb),
    .test_mode(tm), .vga_hs(hs_a), .vga_vs(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIX_DIV(DB), .RENDER_LAT(LB)
  ) u_b (
    .clk(clk), .rst(rst), .h_counter(h_b), .v_counter(v_b), .pix_tick(pt_b),
    .frame_start(fs_b), .color_r_in(cr), .color_g_in(cg), .color_b_in(cb),
    .test_mode(tm), .vga_hs(hs_b), .vga_vs(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Reference: counter position is the number of pixel ticks since reset release;
  // pins show the raster position of RENDER_LAT+1 clks earlier.
  task automatic check_dut(input string nm, input int d, input int lat,
                           input logic [9:0] h_o, input logic [9:0] v_o,
                           input logic pt, input logic fs, input logic hs, input logic vs,
                           input logic [8:0] rgb);
    int n, m, mh, mv, bar;
    logic ehs, evs, efs;
    logic [8:0] ergb;
    n = (k + d - 1) / d;
    chk({nm, ".h_counter"}, h_o, n % HT);
    chk({nm, ".v_counter"}, v_o, (n / HT) % VT);
    chk({nm, ".pix_tick"}, pt, (k % d) == 0);
    efs = (k > 0) && ((k - 1) % d == 0) && (n % (HT * VT) == 0);
    chk({nm, ".frame_start"}, fs, efs);
    if (k < lat + 1) begin
      ehs = 1'b1; evs = 1'b1; ergb = '0;
    end else begin
      m   = k - lat - 1;
      n   = (m + d - 1) / d;
      mh  = n % HT;
      mv  = (n / HT) % VT;
      ehs = !(mh >= HV + HF && mh < HV + HF + HS);
      evs = !(mv >= VV + VF && mv < VV + VF + VS);
      ergb = col_hist[(k - 1) % HIST];
`ifdef VGA_TEST_PATTERN_EN
      if (tm_hist[(k - 1) % HIST]) begin
        bar  = (mh * 8) / HV;
        ergb = {(bar >= 4) ? 3'd7 : 3'd0, ((bar / 2) % 2 == 1) ? 3'd7 : 3'd0,
                (bar % 2 == 1) ? 3'd7 : 3'd0};
      end
`endif
      if (!(mh < HV && mv < VV)) ergb = '0;
    end
    chk({nm, ".vga_hs"}, hs, ehs);
    chk({nm, ".vga_vs"}, vs, evs);
    chk({nm, ".vga_rgb"}, rgb, ergb);
  endtask

  task automatic step(input logic r);
    rst = r;
    cr  = 3'($urandom);
    cg  = 3'($urandom);
    cb  = 3'($urandom);
    tm  = 1'($urandom);
    col_hist[k % HIST] = {cr, cg, cb};
    tm_hist[k % HIST]  = tm;
    @(posedge clk);
    if (r) k = 0; else k++;
    cyc++;
    #1;
    check_dut("a", DA, LA, h_a, v_a, pt_a, fs_a, hs_a, vs_a, {r_a, g_a, b_a});
    check_dut("b", DB, LB, h_b, v_b, pt_b, fs_b, hs_b, vs_b, {r_b, g_b, b_b});
    if (r) begin
      last_fs_a = -1;
      last_fs_b = -1;
    end
    if (fs_a === 1'b1) begin
      if (last_fs_a >= 0) chk("a.frame_period", cyc - last_fs_a, HT * VT * DA);
      last_fs_a = cyc;
    end
    if (fs_b === 1'b1) begin
      if (last_fs_b >= 0) chk("b.frame_period", cyc - last_fs_b, HT * VT * DB);
      last_fs_b = cyc;
    end
  endtask

  initial begin
    repeat (3) step(1'b1);
    repeat (3000) step(1'b0);
    for (int i = 0; i < 2; i++) begin
      int w;
      int rl;
      w  = int'($urandom_range(1000, 1500));
      rl = int'($urandom_range(1, 3));
      repeat (w) step(1'b0);
      repeat (rl) step(1'b1);
    end
    repeat (1500) step(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
